// File: rtl/gated_delay_pipe.sv
// gated_delay_pipe
//   Carries a data stream through DEPTH register stages. Each sample travels
//   with a per-pattern match vector computed from the key presented with it,
//   plus the mode in force when it entered. At the output stage the vector is
//   reduced to a gate (AND in ALL mode, OR in ANY mode). A gated sample is
//   replaced by zero. The OPEN/BLOCK hold FSM then keeps suppressing valid
//   samples for HOLD further cycles. A saturating counter tallies the
//   suppressed samples.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   in/a carry a sample this cycle (no backpressure)
//   in         data to forward
//   a          key, masked and compared against every pattern
//   pat        NUM_PAT patterns, slice i = pattern i (quasi-static)
//   mode       0 = gate when all patterns match, 1 = gate when any matches
//   out_valid  out carries a sample (registered)
//   out        forwarded data, or zero for suppressed or invalid slots
//   blocked    the sample on out was suppressed
//   blk_cnt    number of suppressed valid samples, saturating
//   dbg_state  hold FSM state, 0 = OPEN, 1 = BLOCK
//
// Handshake: a sample is taken on every rising edge where in_valid is high.
// It is presented DEPTH edges later with out_valid high for exactly one cycle.
module gated_delay_pipe #(
    parameter int               DATA_W  = 8,
    parameter int               KEY_W   = 4,
    parameter int               DEPTH   = 2,
    parameter int               NUM_PAT = 2,
    parameter logic [KEY_W-1:0] MASK    = {KEY_W{1'b1}},
    parameter int               HOLD    = 3,
    parameter int               CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in,
    input  logic [KEY_W-1:0]         a,
    input  logic [NUM_PAT*KEY_W-1:0] pat,
    input  logic                     mode,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out,
    output logic                     blocked,
    output logic [CNT_W-1:0]         blk_cnt,
    output logic                     dbg_state
);

    localparam int HC_W = (HOLD < 1) ? 1 : $clog2(HOLD + 1);
    localparam logic [HC_W-1:0] HOLD_HC = HC_W'(HOLD);

    typedef enum logic {
        OPEN  = 1'b0,
        BLOCK = 1'b1
    } state_t;

    // Match vector for the sample currently presented on in/a.
    logic [NUM_PAT-1:0] cond_in;
    always_comb begin
        cond_in = '0;
        for (int i = 0; i < NUM_PAT; i++) begin
            cond_in[i] = ((a & MASK) == pat[i*KEY_W +: KEY_W]);
        end
    end

    // "head" is the sample that the output register loads on the next edge.
    // The output register is the last of the DEPTH stages, so only DEPTH-1
    // stages live in the shift chain below.
    logic               head_v;
    logic [DATA_W-1:0]  head_d;
    logic [NUM_PAT-1:0] head_c;
    logic               head_m;

    generate
        if (DEPTH == 1) begin : g_direct
            assign head_v = in_valid;
            assign head_d = in;
            assign head_c = cond_in;
            assign head_m = mode;
        end else begin : g_pipe
            logic               v_q [DEPTH-1];
            logic [DATA_W-1:0]  d_q [DEPTH-1];
            logic [NUM_PAT-1:0] c_q [DEPTH-1];
            logic               m_q [DEPTH-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < DEPTH - 1; k++) begin
                        v_q[k] <= 1'b0;
                        d_q[k] <= '0;
                        c_q[k] <= '0;
                        m_q[k] <= 1'b0;
                    end
                end else begin
                    v_q[0] <= in_valid;
                    d_q[0] <= in;
                    c_q[0] <= cond_in;
                    m_q[0] <= mode;
                    for (int k = 1; k < DEPTH - 1; k++) begin
                        v_q[k] <= v_q[k-1];
                        d_q[k] <= d_q[k-1];
                        c_q[k] <= c_q[k-1];
                        m_q[k] <= m_q[k-1];
                    end
                end
            end

            assign head_v = v_q[DEPTH-2];
            assign head_d = d_q[DEPTH-2];
            assign head_c = c_q[DEPTH-2];
            assign head_m = m_q[DEPTH-2];
        end
    endgenerate

    logic head_g;
    assign head_g = head_m ? (|head_c) : (&head_c);

    state_t            state_q, state_d;
    logic [HC_W-1:0]   hc_q, hc_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              blocked_q, blocked_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              suppress;

    always_comb begin
        state_d     = state_q;
        hc_d        = hc_q;
        suppress    = 1'b0;
        out_valid_d = head_v;
        out_d       = '0;
        blocked_d   = 1'b0;
        cnt_d       = cnt_q;

        case (state_q)
            OPEN: begin
                if (head_v && head_g) begin
                    suppress = 1'b1;
                    // With HOLD = 0 a block only kills its own sample.
                    if (HOLD > 0) begin
                        state_d = BLOCK;
                        hc_d    = HOLD_HC;
                    end
                end
            end
            BLOCK: begin
                suppress = head_v;
                if (head_v && head_g) begin
                    // A new block, even on the last window cycle, restarts it.
                    hc_d = HOLD_HC;
                end else if (hc_q <= HC_W'(1)) begin
                    state_d = OPEN;
                    hc_d    = '0;
                end else begin
                    // Idle slots age the window as well.
                    hc_d = hc_q - HC_W'(1);
                end
            end
            default: begin
                state_d = OPEN;
                hc_d    = '0;
            end
        endcase

        if (head_v && !suppress) begin
            out_d = head_d;
        end
        blocked_d = suppress;
        if (suppress && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= OPEN;
            hc_q        <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            blocked_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            hc_q        <= hc_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            blocked_q   <= blocked_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign blocked   = blocked_q;
    assign blk_cnt   = cnt_q;
    assign dbg_state = (state_q == BLOCK);

endmodule

// File: tb/tb_gated_delay_pipe.sv
module tb_gated_delay_pipe;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] din;
    logic [3:0] a;
    logic [7:0] pat;
    logic       mode;

    // ua: DEPTH 2, HOLD 0 | ub: DEPTH 2, HOLD 3 | uc: DEPTH 2, HOLD 2, CNT_W 2 | ud: DEPTH 3, HOLD 0
    logic       a_ov, a_blk, a_st;
    logic [7:0] a_out, a_cnt;
    logic       b_ov, b_blk, b_st;
    logic [7:0] b_out, b_cnt;
    logic       c_ov, c_blk, c_st;
    logic [7:0] c_out;
    logic [1:0] c_cnt;
    logic       d_ov, d_blk, d_st;
    logic [7:0] d_out, d_cnt;

    int checks = 0;
    int errors = 0;

    gated_delay_pipe #(.DEPTH(2), .HOLD(0)) ua (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(din), .a(a), .pat(pat), .mode(mode),
        .out_valid(a_ov), .out(a_out), .blocked(a_blk), .blk_cnt(a_cnt), .dbg_state(a_st)
    );
    gated_delay_pipe #(.DEPTH(2), .HOLD(3)) ub (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(din), .a(a), .pat(pat), .mode(mode),
        .out_valid(b_ov), .out(b_out), .blocked(b_blk), .blk_cnt(b_cnt), .dbg_state(b_st)
    );
    gated_delay_pipe #(.DEPTH(2), .HOLD(2), .CNT_W(2)) uc (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(din), .a(a), .pat(pat), .mode(mode),
        .out_valid(c_ov), .out(c_out), .blocked(c_blk), .blk_cnt(c_cnt), .dbg_state(c_st)
    );
    gated_delay_pipe #(.DEPTH(3), .HOLD(0)) ud (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(din), .a(a), .pat(pat), .mode(mode),
        .out_valid(d_ov), .out(d_out), .blocked(d_blk), .blk_cnt(d_cnt), .dbg_state(d_st)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one slot, wait for the edge, settle away from it.
    task automatic step(input logic v, input logic [7:0] d, input logic [3:0] k);
        in_valid = v;
        din      = d;
        a        = k;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 8'h00, 4'h0);
        rst = 1'b0;
    endtask

    logic [7:0] t1_d [8] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    logic [3:0] t1_a [8] = '{4'h0, 4'hA, 4'h3, 4'hA, 4'h0, 4'h5, 4'hF, 4'hA};
    logic [7:0] t2_d [5] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
    logic [3:0] t2_a [5] = '{4'h3, 4'h5, 4'hA, 4'h7, 4'h9};

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        din      = 8'h00;
        a        = 4'h0;
        pat      = {4'hA, 4'h0};
        mode     = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // reset state
        chk("rst_ov", a_ov, 0);
        chk("rst_out", a_out, 0);
        chk("rst_blk", a_blk, 0);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_state", b_st, 0);

        // 1: ALL mode, patterns 0 and A can never both match; nothing gated
        mode = 1'b0;
        for (int s = 0; s < 10; s++) begin
            if (s < 8) step(1'b1, t1_d[s], t1_a[s]);
            else       step(1'b0, 8'h00, 4'h0);
            if (s >= 1 && s <= 8) begin
                chk("t1_ua_ov", a_ov, 1);
                chk("t1_ua_out", a_out, t1_d[s-1]);
                chk("t1_ua_blk", a_blk, 0);
            end else begin
                chk("t1_ua_idle", a_ov, 0);
            end
            if (s >= 2) begin
                chk("t1_ud_ov", d_ov, 1);
                chk("t1_ud_out", d_out, t1_d[s-2]);
            end else begin
                chk("t1_ud_idle", d_ov, 0);
            end
        end
        chk("t1_cnt", a_cnt, 0);

        // 2: ANY mode, HOLD 0, only the third sample matches
        do_reset();
        mode = 1'b1;
        for (int s = 0; s < 6; s++) begin
            if (s < 5) step(1'b1, t2_d[s], t2_a[s]);
            else       step(1'b0, 8'h00, 4'h0);
            if (s >= 1) begin
                chk("t2_out", a_out, (s == 3) ? 8'h00 : t2_d[s-1]);
                chk("t2_blk", a_blk, (s == 3) ? 1 : 0);
            end
        end
        chk("t2_cnt", a_cnt, 1);

        // 3a: HOLD 3, single match then five non-matching samples
        do_reset();
        step(1'b1, 8'h31, 4'hA);
        step(1'b1, 8'h32, 4'h3); chk("t3a_s0_blk", b_blk, 1); chk("t3a_s0_out", b_out, 0);
        step(1'b1, 8'h33, 4'h3); chk("t3a_s1_blk", b_blk, 1);
        step(1'b1, 8'h34, 4'h3); chk("t3a_s2_blk", b_blk, 1);
        step(1'b1, 8'h35, 4'h3); chk("t3a_s3_blk", b_blk, 1); chk("t3a_s3_out", b_out, 0);
        step(1'b1, 8'h36, 4'h3); chk("t3a_s4_blk", b_blk, 0); chk("t3a_s4_out", b_out, 8'h35);
        step(1'b0, 8'h00, 4'h0); chk("t3a_s5_out", b_out, 8'h36);
        chk("t3a_cnt", b_cnt, 4);

        // 3b: second match two samples later extends the window through k+5
        do_reset();
        step(1'b1, 8'h41, 4'hA);
        step(1'b1, 8'h42, 4'h3);
        step(1'b1, 8'h43, 4'hA);
        step(1'b1, 8'h44, 4'h3);
        step(1'b1, 8'h45, 4'h3);
        step(1'b1, 8'h46, 4'h3);
        step(1'b1, 8'h47, 4'h3); chk("t3b_s5_blk", b_blk, 1); chk("t3b_s5_out", b_out, 0);
        step(1'b0, 8'h00, 4'h0); chk("t3b_s6_blk", b_blk, 0); chk("t3b_s6_out", b_out, 8'h47);
        chk("t3b_cnt", b_cnt, 6);

        // 4: HOLD 2, window expires during idle slots
        do_reset();
        step(1'b1, 8'h51, 4'hA);
        step(1'b0, 8'h00, 4'h0); chk("t4_blk", c_blk, 1); chk("t4_cnt1", c_cnt, 1);
        step(1'b0, 8'h00, 4'h0); chk("t4_idle_ov", c_ov, 0); chk("t4_idle_blk", c_blk, 0);
        chk("t4_st_block", c_st, 1);
        step(1'b0, 8'h00, 4'h0); chk("t4_st_open", c_st, 0);
        step(1'b1, 8'h52, 4'h3);
        step(1'b0, 8'h00, 4'h0); chk("t4_fwd_out", c_out, 8'h52); chk("t4_fwd_blk", c_blk, 0);
        chk("t4_cnt", c_cnt, 1);

        // 5: reset with samples in flight and an active block
        do_reset();
        step(1'b1, 8'h61, 4'hA);
        step(1'b1, 8'h62, 4'h3);
        step(1'b1, 8'h63, 4'h3); chk("t5_pre_st", b_st, 1);
        rst = 1'b1;
        step(1'b1, 8'h64, 4'h3);
        rst = 1'b0;
        chk("t5_rst_ov", b_ov, 0); chk("t5_rst_cnt", b_cnt, 0); chk("t5_rst_st", b_st, 0);
        step(1'b1, 8'h65, 4'h3); chk("t5_c1_ov", b_ov, 0);
        step(1'b0, 8'h00, 4'h0); chk("t5_c2_ov", b_ov, 1);
        chk("t5_c2_out", b_out, 8'h65); chk("t5_c2_blk", b_blk, 0); chk("t5_c2_cnt", b_cnt, 0);

        // 6: CNT_W 2 saturates at 3
        do_reset();
        for (int s = 0; s < 7; s++) begin
            if (s < 6) step(1'b1, 8'h71 + 8'(s), 4'hA);
            else       step(1'b0, 8'h00, 4'h0);
            if (s >= 1) chk("t6_cnt", c_cnt, (s < 3) ? s : 3);
        end

        // 7: ALL mode gates when both patterns match; pat/mode taken at entry
        do_reset();
        mode = 1'b0;
        pat  = {4'hA, 4'hA};
        step(1'b1, 8'h81, 4'hA);
        pat  = {4'hA, 4'h0};
        step(1'b1, 8'h82, 4'hA); chk("t7_all_blk", a_blk, 1); chk("t7_all_out", a_out, 0);
        step(1'b0, 8'h00, 4'h0); chk("t7_fwd_blk", a_blk, 0); chk("t7_fwd_out", a_out, 8'h82);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
